// File: rtl/quant_pkg.sv
// Shared types and constants for the quantizer scheduling path.
//   comp_e        : component id carried with each coefficient block
//   qtag_t        : per-block tag travelling alongside the quantizer pipeline
//   sched_state_e : MCU scheduler states
//   QLAT_DEFAULT  : quantizer enable-to-Q latency, shared with the quantizers
package quant_pkg;

  localparam int QLAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  typedef struct packed {
    logic  valid;
    comp_e comp;
    logic  last_mcu;
    logic  last_frame;
  } qtag_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_Y,
    ISSUE_CB,
    ISSUE_CR,
    DRAIN
  } sched_state_e;

endpackage

// File: rtl/quant_tag_pipe.sv
// QLAT-deep shift register of qtag_t, shifting every cycle, so a tag loaded
// on a quantizer-enable edge leaves the last stage in step with that block's Q.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous flush of all stages
//   in_tag     : tag loaded into stage 0 each cycle (valid=0 when idle)
//   out_tag    : tag in the last stage
//   any_valid  : a tag is still pending behind the last stage
module quant_tag_pipe
  import quant_pkg::*;
#(
  parameter int QLAT = QLAT_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  qtag_t in_tag,
  output qtag_t out_tag,
  output logic  any_valid
);

  qtag_t stage_q [QLAT];
  qtag_t stage_d [QLAT];

  always_comb begin
    stage_d[0] = clear ? '0 : in_tag;
  end

  generate
    for (genvar gi = 1; gi < QLAT; gi++) begin : g_shift
      always_comb begin
        stage_d[gi] = clear ? '0 : stage_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QLAT; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < QLAT; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign out_tag = stage_q[QLAT-1];

  // The last stage is excluded: it empties on the coming edge. This lets the
  // scheduler signal done in the cycle right after the final result.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < QLAT - 1; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

endmodule

// File: rtl/quant_mcu_scheduler.sv
// Sequences the Y, Cb and Cr quantizers in MCU order for one frame, grants
// each component's block handshake, pulses the matching quantizer enable and
// emits a merged, latency-aligned result stream for the entropy-coder mux.
// Downstream flow control is by credits because the quantizers cannot stall.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   start, mcu_total            : frame start pulse and MCU count (sampled on start)
//   y/cb/cr_valid, y/cb/cr_ready: per-component block handshake
//   q_en_y/cb/cr                : quantizer enable pulses (same cycle as fire)
//   crd_return                  : downstream freed one buffer slot
//   res_valid, res_comp,
//   res_last_mcu, res_last_frame: merged result stream
//   busy, done, crd_err         : frame in progress, completion pulse, credit overflow
module quant_mcu_scheduler
  import quant_pkg::*;
#(
  parameter int QLAT      = QLAT_DEFAULT,
  parameter int Y_PER_MCU = 4,
  parameter int CREDITS   = 2,
  parameter int MCU_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MCU_W-1:0] mcu_total,
  input  logic             y_valid,
  input  logic             cb_valid,
  input  logic             cr_valid,
  output logic             y_ready,
  output logic             cb_ready,
  output logic             cr_ready,
  output logic             q_en_y,
  output logic             q_en_cb,
  output logic             q_en_cr,
  input  logic             crd_return,
  output logic             res_valid,
  output logic [1:0]       res_comp,
  output logic             res_last_mcu,
  output logic             res_last_frame,
  output logic             busy,
  output logic             done,
  output logic             crd_err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int YW = (Y_PER_MCU > 1) ? $clog2(Y_PER_MCU) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [YW-1:0] Y_LAST   = YW'(Y_PER_MCU - 1);

  sched_state_e     state_q, state_d;
  logic [MCU_W-1:0] mcu_total_q, mcu_total_d;
  logic [MCU_W-1:0] mcu_cnt_q, mcu_cnt_d;
  logic [YW-1:0]    y_cnt_q, y_cnt_d;
  logic [CW-1:0]    credits_q, credits_d;
  logic             crd_err_q, crd_err_d;
  logic             done_q, done_d;

  logic  fire_y, fire_cb, fire_cr, fire;
  logic  last_mcu_of_frame;
  logic  pipe_clear, pipe_pending;
  qtag_t tag_in, tag_out;

  // Grants: only the component being served, and only with a free slot.
  assign y_ready  = (state_q == ISSUE_Y)  && (credits_q != '0);
  assign cb_ready = (state_q == ISSUE_CB) && (credits_q != '0);
  assign cr_ready = (state_q == ISSUE_CR) && (credits_q != '0);

  assign fire_y  = y_valid  && y_ready;
  assign fire_cb = cb_valid && cb_ready;
  assign fire_cr = cr_valid && cr_ready;
  assign fire    = fire_y || fire_cb || fire_cr;

  assign q_en_y  = fire_y;
  assign q_en_cb = fire_cb;
  assign q_en_cr = fire_cr;

  assign last_mcu_of_frame = (mcu_cnt_q == mcu_total_q - MCU_W'(1));

  always_comb begin
    tag_in            = '0;
    tag_in.valid      = fire;
    tag_in.comp       = fire_cb ? COMP_CB : (fire_cr ? COMP_CR : COMP_Y);
    tag_in.last_mcu   = fire_cr;
    tag_in.last_frame = fire_cr && last_mcu_of_frame;
  end

  always_comb begin
    state_d     = state_q;
    mcu_total_d = mcu_total_q;
    mcu_cnt_d   = mcu_cnt_q;
    y_cnt_d     = y_cnt_q;
    done_d      = 1'b0;
    pipe_clear  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pipe_clear = 1'b1;
          if (mcu_total != '0) begin
            mcu_total_d = mcu_total;
            mcu_cnt_d   = '0;
            y_cnt_d     = '0;
            state_d     = ISSUE_Y;
          end else begin
            // Empty frame: pass through DRAIN so done still pulses once.
            state_d = DRAIN;
          end
        end
      end
      ISSUE_Y: begin
        if (fire_y) begin
          if (y_cnt_q == Y_LAST) begin
            y_cnt_d = '0;
            state_d = ISSUE_CB;
          end else begin
            y_cnt_d = y_cnt_q + YW'(1);
          end
        end
      end
      ISSUE_CB: begin
        if (fire_cb) state_d = ISSUE_CR;
      end
      ISSUE_CR: begin
        if (fire_cr) begin
          if (last_mcu_of_frame) begin
            state_d = DRAIN;
          end else begin
            mcu_cnt_d = mcu_cnt_q + MCU_W'(1);
            state_d   = ISSUE_Y;
          end
        end
      end
      DRAIN: begin
        if (!pipe_pending) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit counter: a fire consumes a slot, a return frees one; both at once
  // cancel. A return with every slot already free is a downstream protocol
  // error: hold the count and latch crd_err.
  always_comb begin
    credits_d = credits_q;
    crd_err_d = crd_err_q;
    if (fire && !crd_return) begin
      credits_d = credits_q - CW'(1);
    end else if (!fire && crd_return) begin
      if (credits_q == CRED_MAX) crd_err_d = 1'b1;
      else                       credits_d = credits_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mcu_total_q <= '0;
      mcu_cnt_q   <= '0;
      y_cnt_q     <= '0;
      credits_q   <= CRED_MAX;
      crd_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcu_total_q <= mcu_total_d;
      mcu_cnt_q   <= mcu_cnt_d;
      y_cnt_q     <= y_cnt_d;
      credits_q   <= credits_d;
      crd_err_q   <= crd_err_d;
      done_q      <= done_d;
    end
  end

  quant_tag_pipe #(
    .QLAT (QLAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .clear     (pipe_clear),
    .in_tag    (tag_in),
    .out_tag   (tag_out),
    .any_valid (pipe_pending)
  );

  assign res_valid      = tag_out.valid;
  assign res_comp       = tag_out.valid ? 2'(tag_out.comp) : 2'd0;
  assign res_last_mcu   = tag_out.valid && tag_out.last_mcu;
  assign res_last_frame = tag_out.valid && tag_out.last_frame;

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign crd_err = crd_err_q;

endmodule
